activate: RTL and testbench

//  Nonlinear stage directly downstream of a neuron's associate (inner-product) stage.

---
 rtl/activate.sv | 146 ++++++++++++++
 tb/tb_activate.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activate.sv
// Hard-sigmoid activation stage with a training backward path (error times derivative).
// Define ACTIVATE_LEAKY_EN to give saturated samples a small leaky derivative instead of zero.
module activate #(
  parameter int SHIFT = 2,
  parameter int LEAK  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        arg_stb,
  input  logic [15:0] arg_dat,
  output logic        arg_rdy,
  output logic        res_stb,
  output logic [7:0]  res_dat,
  input  logic        res_rdy,
  input  logic        err_stb,
  input  logic [15:0] err_dat,
  output logic        err_rdy,
  output logic        fbk_stb,
  output logic [15:0] fbk_dat,
  input  logic        fbk_rdy
);

`ifdef ACTIVATE_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  localparam logic [8:0] DERIV = 9'(256 >> SHIFT);
  localparam logic [8:0] SAT_G = LEAKY ? 9'(256 >> LEAK) : 9'd0;

  typedef enum logic [2:0] {
    S_ARG = 3'd0,
    S_ACT = 3'd1,
    S_RES = 3'd2,
    S_ERR = 3'd3,
    S_FBK = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic signed [15:0] x_reg;
  logic               sat_reg;
  logic [7:0]         res_dat_reg;
  logic               res_stb_reg;
  logic [15:0]        fbk_dat_reg;
  logic               fbk_stb_reg;

  logic arg_ack, res_ack, err_ack, fbk_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_ARG;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    arg_rdy    = 1'b0;
    err_rdy    = 1'b0;
    case (state_reg)
      S_ARG: begin
        arg_rdy = 1'b1;
        if (arg_stb) state_next = S_ACT;
      end
      S_ACT: state_next = S_RES;
      S_RES: if (res_rdy) state_next = en ? S_ERR : S_ARG;
      S_ERR: begin
        err_rdy = 1'b1;
        if (err_stb) state_next = S_FBK;
      end
      S_FBK: if (fbk_rdy) state_next = S_ARG;
      default: state_next = S_ARG;
    endcase
  end

  assign arg_ack = arg_stb & arg_rdy;
  assign res_ack = res_stb_reg & res_rdy;
  assign err_ack = err_stb & err_rdy;
  assign fbk_ack = fbk_stb_reg & fbk_rdy;

  // Forward: t = x/2^SHIFT + 0.5, then clamp into Q0.8.
  logic signed [16:0] t;
  logic [7:0]         y_next;
  logic               sat_next;

  always_comb begin
    t        = ($signed({x_reg[15], x_reg}) >>> SHIFT) + 17'sd128;
    y_next   = t[7:0];
    sat_next = 1'b0;
    if (t < 17'sd0) begin
      y_next   = 8'h00;
      sat_next = 1'b1;
    end else if (t > 17'sd255) begin
      y_next   = 8'hFF;
      sat_next = 1'b1;
    end
  end

  // Backward: delta = err * g / 256, arithmetic shift floors toward -inf.
  logic [8:0]         g;
  logic signed [24:0] prod;
  logic signed [24:0] p;
  logic [15:0]        delta;

  always_comb begin
    g    = sat_reg ? SAT_G : DERIV;
    prod = $signed({{9{err_dat[15]}}, err_dat}) * $signed({16'd0, g});
    p    = prod >>> 8;
    if (p > 25'sd32767)       delta = 16'h7FFF;
    else if (p < -25'sd32768) delta = 16'h8000;
    else                      delta = p[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg       <= '0;
      sat_reg     <= 1'b0;
      res_dat_reg <= '0;
      res_stb_reg <= 1'b0;
      fbk_dat_reg <= '0;
      fbk_stb_reg <= 1'b0;
    end else begin
      if (arg_ack) x_reg <= arg_dat;
      if (state_reg == S_ACT) begin
        res_dat_reg <= y_next;
        sat_reg     <= sat_next;
        res_stb_reg <= 1'b1;
      end else if (res_ack) begin
        res_stb_reg <= 1'b0;
      end
      if (err_ack) begin
        fbk_dat_reg <= delta;
        fbk_stb_reg <= 1'b1;
      end else if (fbk_ack) begin
        fbk_stb_reg <= 1'b0;
      end
    end
  end

  assign res_stb = res_stb_reg;
  assign res_dat = res_dat_reg;
  assign fbk_stb = fbk_stb_reg;
  assign fbk_dat = fbk_dat_reg;

endmodule

// File: tb/tb_activate.sv
// Directed self-checking bench for activate: reset, forward saturation, training path, backpressure.
`timescale 1ns/1ps
module tb_activate;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        arg_stb = 1'b0;
  logic [15:0] arg_dat = '0;
  logic        arg_rdy;
  logic        res_stb;
  logic [7:0]  res_dat;
  logic        res_rdy = 1'b0;
  logic        err_stb = 1'b0;
  logic [15:0] err_dat = '0;
  logic        err_rdy;
  logic        fbk_stb;
  logic [15:0] fbk_dat;
  logic        fbk_rdy = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int err_rdy_seen = 0;
  bit watch_err = 1'b0;

  activate dut (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
    .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
    .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch_err && err_rdy) err_rdy_seen++;

  // Drivers: each returns at the negedge after the accepting posedge.
  task automatic send_arg(input logic [15:0] x);
    bit ok = 1'b0;
    arg_stb = 1'b1;
    arg_dat = x;
    for (int i = 0; i < 20; i++) begin
      if (arg_rdy) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    @(negedge clk);
    arg_stb = 1'b0;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL arg_handshake: got no arg_rdy, want arg_rdy=1 within 20 cycles"); end
  endtask

  task automatic recv_res(output logic [7:0] d);
    bit ok = 1'b0;
    d = 8'hxx;
    res_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_stb) begin d = res_dat; ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    @(negedge clk);
    res_rdy = 1'b0;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL res_handshake: got no res_stb, want res_stb=1 within 20 cycles"); end
  endtask

  task automatic send_err(input logic [15:0] e);
    bit ok = 1'b0;
    err_stb = 1'b1;
    err_dat = e;
    for (int i = 0; i < 20; i++) begin
      if (err_rdy) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    @(negedge clk);
    err_stb = 1'b0;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL err_handshake: got no err_rdy, want err_rdy=1 within 20 cycles"); end
  endtask

  task automatic recv_fbk(output logic [15:0] d);
    bit ok = 1'b0;
    d = 16'hxxxx;
    fbk_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (fbk_stb) begin d = fbk_dat; ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    @(negedge clk);
    fbk_rdy = 1'b0;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL fbk_handshake: got no fbk_stb, want fbk_stb=1 within 20 cycles"); end
  endtask

  task automatic test_reset();
    logic [7:0] y;
    repeat (2) @(negedge clk);
    compared++;
    if ({res_stb, fbk_stb, res_dat, fbk_dat, arg_rdy, err_rdy} !== {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state: got res_stb=%b fbk_stb=%b res_dat=%h fbk_dat=%h arg_rdy=%b err_rdy=%b, want 0 0 00 0000 1 0",
               res_stb, fbk_stb, res_dat, fbk_dat, arg_rdy, err_rdy);
    end
    rst = 1'b1;
    @(negedge clk);
    send_arg(16'h0100);
    @(negedge clk);
    compared++;
    if (res_stb !== 1'b1 || res_dat !== 8'hC0) begin
      mismatched++; $display("FAIL reset_pre_res: got res_stb=%b res_dat=%h, want 1 c0", res_stb, res_dat);
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if (res_stb !== 1'b0 || res_dat !== 8'h00) begin
      mismatched++; $display("FAIL reset_async: got res_stb=%b res_dat=%h, want 0 00", res_stb, res_dat);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (arg_rdy !== 1'b1 || res_stb !== 1'b0) begin
      mismatched++; $display("FAIL reset_release: got arg_rdy=%b res_stb=%b, want 1 0", arg_rdy, res_stb);
    end
    // x/sat cleared: a training pass with no new arg would be impossible, so just confirm a fresh sample works.
    en = 1'b0;
    send_arg(16'hFF00);
    recv_res(y);
    compared++;
    if (y !== 8'h40) begin mismatched++; $display("FAIL reset_first_sample: got %h, want 40", y); end
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [7:0] y;
    en = 1'b0;
    watch_err = 1'b1;
    err_stb = 1'b1;
    err_dat = 16'h1234;
    send_arg(16'h0000);
    compared++;
    if (res_stb !== 1'b0) begin mismatched++; $display("FAIL latency_act: got res_stb=%b one cycle after ack, want 0", res_stb); end
    @(negedge clk);
    compared++;
    if (res_stb !== 1'b1 || res_dat !== 8'h80) begin
      mismatched++; $display("FAIL latency_res: got res_stb=%b res_dat=%h two cycles after ack, want 1 80", res_stb, res_dat);
    end
    recv_res(y);
    compared++;
    if (arg_rdy !== 1'b1 || res_stb !== 1'b0 || res_dat !== 8'h80) begin
      mismatched++; $display("FAIL back_to_arg: got arg_rdy=%b res_stb=%b res_dat=%h, want 1 0 80", arg_rdy, res_stb, res_dat);
    end
    repeat (3) @(negedge clk);
    err_stb = 1'b0;
    watch_err = 1'b0;
    compared++;
    if (err_rdy_seen !== 0) begin mismatched++; $display("FAIL err_rdy_idle: got %0d cycles high, want 0", err_rdy_seen); end
    $display("basic: x=0000 y=%h", y);
  endtask

  task automatic test_saturation();
    logic [15:0] xs [6] = '{16'h01FF, 16'h0200, 16'hFE00, 16'hFDFF, 16'h7FFF, 16'h8000};
    logic [7:0]  ys [6] = '{8'hFF,   8'hFF,   8'h00,   8'h00,   8'hFF,   8'h00};
    logic [7:0]  y;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_arg(xs[i]);
      recv_res(y);
      compared++;
      if (y !== ys[i]) begin mismatched++; $display("FAIL sat_%0d: x=%h got %h, want %h", i, xs[i], y, ys[i]); end
      else $display("sat: x=%h y=%h", xs[i], y);
    end
  endtask

  task automatic test_train();
    logic [15:0] xs [8] = '{16'h0100, 16'h0100, 16'h0400, 16'h01FF, 16'h0200, 16'hFDFF, 16'hFE00, 16'hFF00};
    logic [15:0] es [8] = '{16'h0100, 16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h7FFF, 16'h7FFF, 16'hFFFF};
    logic [7:0]  ys [8] = '{8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h40};
`ifdef ACTIVATE_LEAKY_EN
    logic [15:0] fs [8] = '{16'h0040, 16'hE000, 16'hFC00, 16'h0040, 16'h0008, 16'h03FF, 16'h1FFF, 16'hFFFF};
`else
    logic [15:0] fs [8] = '{16'h0040, 16'hE000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h1FFF, 16'hFFFF};
`endif
    logic [7:0]  y;
    logic [15:0] f;
    for (int i = 0; i < 8; i++) begin
      en = 1'b0;
      send_arg(xs[i]);
      en = 1'b1;
      recv_res(y);
      en = 1'b0;
      send_err(es[i]);
      recv_fbk(f);
      compared++;
      if (y !== ys[i] || f !== fs[i]) begin
        mismatched++;
        $display("FAIL train_%0d: x=%h err=%h got y=%h fbk=%h, want y=%h fbk=%h", i, xs[i], es[i], y, f, ys[i], fs[i]);
      end else $display("train: x=%h err=%h y=%h fbk=%h", xs[i], es[i], y, f);
    end
    // en high only outside the res_ack cycle must not start a backward pass
    en = 1'b1;
    send_arg(16'h0000);
    en = 1'b0;
    recv_res(y);
    en = 1'b1;
    @(negedge clk);
    compared++;
    if (err_rdy !== 1'b0 || arg_rdy !== 1'b1) begin
      mismatched++; $display("FAIL en_sampled: got err_rdy=%b arg_rdy=%b, want 0 1", err_rdy, arg_rdy);
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int dups = 0;
    logic [15:0] f;
    en = 1'b1;
    send_arg(16'h0100);
    arg_stb = 1'b1;
    arg_dat = 16'h7FFF;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (res_stb !== 1'b1 || res_dat !== 8'hC0 || err_rdy !== 1'b0) bad++;
      @(negedge clk);
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL res_hold: got %0d unstable cycles, want 0", bad); end
    arg_stb = 1'b0;
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    en = 1'b0;
    compared++;
    if (res_stb !== 1'b0 || err_rdy !== 1'b1) begin
      mismatched++; $display("FAIL res_single_ack: got res_stb=%b err_rdy=%b, want 0 1", res_stb, err_rdy);
    end
    send_err(16'h0100);
    bad = 0;
    err_stb = 1'b1;
    err_dat = 16'h8000;
    for (int i = 0; i < 10; i++) begin
      if (fbk_stb !== 1'b1 || fbk_dat !== 16'h0040) bad++;
      @(negedge clk);
    end
    err_stb = 1'b0;
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL fbk_hold: got %0d unstable cycles, want 0", bad); end
    fbk_rdy = 1'b1;
    @(negedge clk);
    fbk_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fbk_stb !== 1'b0 || res_stb !== 1'b0 || arg_rdy !== 1'b1) dups++;
      @(negedge clk);
    end
    compared++;
    if (dups != 0) begin mismatched++; $display("FAIL fbk_single_ack: got %0d cycles with stb or not idle, want 0", dups); end
    recv_fbk_none(f);
    $display("backpressure: held res=c0 fbk=0040, last fbk_dat=%h", f);
  endtask

  // fbk_dat keeps its value after the acknowledge
  task automatic recv_fbk_none(output logic [15:0] d);
    d = fbk_dat;
    compared++;
    if (d !== 16'h0040) begin mismatched++; $display("FAIL fbk_dat_hold: got %h, want 0040", d); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_basic();
        test_saturation();
        test_train();
        test_backpressure();
      end
      begin
        #200000;
        $display("FAIL global_timeout: got no completion, want finish within 200us");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
